// File: rtl/game_frame_renderer_if.sv
// Pixel plot bus from the frame renderer to the VGA adapter.
// Master offers x/y/color under plot_valid; slave accepts with plot_ready.
interface game_frame_renderer_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
) ();
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic               plot_valid;
    logic               plot_ready;

    modport master (output x, y, color, plot_valid, input plot_ready);
    modport slave  (input x, y, color, plot_valid, output plot_ready);
endinterface

// File: rtl/game_frame_renderer.sv
// Raster-scan compositor (background, ground, obstacles, dino sprite); 4 cycles per pixel.
// Each pixel is held on the plot bus until plot_ready; scanning stalls while the adapter is not ready.
module game_frame_renderer #(
    parameter int X_W        = 8,
    parameter int Y_W        = 8,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int N_OBS      = 2,
    parameter int OBS_W      = 8,
    parameter int COLOR_W    = 3,
    parameter int GROUND_TOP = 100,
    parameter int DINO_LEFT  = 10,
    parameter int DINO_W     = 16,
    parameter int DINO_H     = 16,
    parameter logic [COLOR_W-1:0] COL_BG   = 3'b111,
    parameter logic [COLOR_W-1:0] COL_GRND = 3'b000,
    parameter logic [COLOR_W-1:0] COL_MASK = 3'b101
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     frame_start,
    input  logic [Y_W-1:0]           dino_y,
    input  logic [N_OBS*X_W-1:0]     obs_x,
    input  logic [N_OBS*Y_W-1:0]     obs_h,
    input  logic [N_OBS*COLOR_W-1:0] obs_col,
    input  logic [N_OBS-1:0]         obs_en,
    output logic [X_W-1:0]           sprite_col,
    output logic [Y_W-1:0]           sprite_row,
    input  logic [COLOR_W-1:0]       sprite_color,
    game_frame_renderer_if.master    plot,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_overrun
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_COMP,
        S_EMIT
    } state_t;

    localparam logic [X_W-1:0] XL     = X_W'(DINO_LEFT);
    localparam logic [X_W:0]   XR_E   = (X_W+1)'(DINO_LEFT + DINO_W);
    localparam logic [X_W-1:0] XMAX_L = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMAX_L = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] GT_L   = Y_W'(GROUND_TOP);
    localparam logic [Y_W:0]   GT_E   = (Y_W+1)'(GROUND_TOP);
    localparam logic [Y_W:0]   DH_E   = (Y_W+1)'(DINO_H);
    localparam logic [X_W:0]   OW_E   = (X_W+1)'(OBS_W);

    state_t r_state;
    state_t w_state_nxt;

    logic [X_W-1:0]           r_sx;
    logic [Y_W-1:0]           r_sy;
    logic [Y_W-1:0]           r_dy;
    logic [N_OBS*X_W-1:0]     r_obs_x;
    logic [N_OBS*Y_W-1:0]     r_obs_h;
    logic [N_OBS*COLOR_W-1:0] r_obs_col;
    logic [N_OBS-1:0]         r_obs_en;

    logic                     r_hit_grnd;
    logic                     r_hit_dino;
    logic [N_OBS-1:0]         r_hit_obs;

    logic [X_W-1:0]           r_sprite_col;
    logic [Y_W-1:0]           r_sprite_row;
    logic [X_W-1:0]           r_x;
    logic [Y_W-1:0]           r_y;
    logic [COLOR_W-1:0]       r_color;
    logic                     r_plot_valid;
    logic                     r_busy;
    logic                     r_frame_done;
    logic                     r_frame_overrun;

    logic                     w_hit_grnd;
    logic                     w_hit_dino;
    logic [N_OBS-1:0]         w_hit_obs;
    logic                     w_accept;
    logic                     w_last;
    logic [COLOR_W-1:0]       w_obs_color;
    logic [COLOR_W-1:0]       w_pix_color;

    // Bound sums carry one extra bit so boxes near the right/bottom edge clip instead of wrapping.
    assign w_hit_grnd = (r_sy >= GT_L);
    assign w_hit_dino = (r_sx >= XL) && ({1'b0, r_sx} < XR_E) &&
                        (r_sy >= r_dy) && ({1'b0, r_sy} < ({1'b0, r_dy} + DH_E));

    for (genvar g = 0; g < N_OBS; g++) begin : g_obs
        logic [X_W-1:0] w_ox;
        logic [Y_W-1:0] w_oh;
        logic [X_W:0]   w_oright;
        logic [Y_W:0]   w_otop;

        assign w_ox     = r_obs_x[g*X_W +: X_W];
        assign w_oh     = r_obs_h[g*Y_W +: Y_W];
        assign w_oright = {1'b0, w_ox} + OW_E;
        // Obstacles taller than the ground line fill the whole column above it.
        assign w_otop   = ({1'b0, w_oh} > GT_E) ? '0 : (GT_E - {1'b0, w_oh});
        assign w_hit_obs[g] = r_obs_en[g] && (w_oh != '0) &&
                              (r_sx >= w_ox) && ({1'b0, r_sx} < w_oright) &&
                              ({1'b0, r_sy} >= w_otop);
    end

    assign w_accept = (r_state == S_EMIT) && r_plot_valid && plot.plot_ready;
    assign w_last   = (r_sx == XMAX_L) && (r_sy == YMAX_L);

    always_comb begin
        w_obs_color = COL_BG;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (r_hit_obs[i]) begin
                w_obs_color = r_obs_col[i*COLOR_W +: COLOR_W];
            end
        end
        w_pix_color = w_obs_color;
        if (r_hit_grnd) begin
            w_pix_color = COL_GRND;
        end else if (r_hit_dino && (sprite_color != COL_MASK)) begin
            w_pix_color = sprite_color;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (frame_start) w_state_nxt = S_ADDR;
            S_ADDR: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_COMP;
            S_COMP: w_state_nxt = S_EMIT;
            S_EMIT: if (w_accept) w_state_nxt = w_last ? S_IDLE : S_ADDR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sx            <= '0;
            r_sy            <= '0;
            r_dy            <= '0;
            r_obs_x         <= '0;
            r_obs_h         <= '0;
            r_obs_col       <= '0;
            r_obs_en        <= '0;
            r_hit_grnd      <= 1'b0;
            r_hit_dino      <= 1'b0;
            r_hit_obs       <= '0;
            r_sprite_col    <= '0;
            r_sprite_row    <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_color         <= COL_BG;
            r_plot_valid    <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_overrun <= 1'b0;
        end else begin
            r_frame_done    <= 1'b0;
            r_frame_overrun <= frame_start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_dy      <= dino_y;
                        r_obs_x   <= obs_x;
                        r_obs_h   <= obs_h;
                        r_obs_col <= obs_col;
                        r_obs_en  <= obs_en;
                        r_sx      <= '0;
                        r_sy      <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    r_hit_grnd   <= w_hit_grnd;
                    r_hit_dino   <= w_hit_dino;
                    r_hit_obs    <= w_hit_obs;
                    r_sprite_col <= r_sx - XL;
                    r_sprite_row <= r_sy - r_dy;
                end
                S_COMP: begin
                    r_x          <= r_sx;
                    r_y          <= r_sy;
                    r_color      <= w_pix_color;
                    r_plot_valid <= 1'b1;
                end
                S_EMIT: begin
                    if (w_accept) begin
                        r_plot_valid <= 1'b0;
                        if (w_last) begin
                            r_sx         <= '0;
                            r_sy         <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else if (r_sx == XMAX_L) begin
                            r_sx <= '0;
                            r_sy <= r_sy + 1'b1;
                        end else begin
                            r_sx <= r_sx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sprite_col      = r_sprite_col;
    assign sprite_row      = r_sprite_row;
    assign plot.x          = r_x;
    assign plot.y          = r_y;
    assign plot.color      = r_color;
    assign plot.plot_valid = r_plot_valid;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign frame_overrun   = r_frame_overrun;
endmodule

// File: tb/tb_game_frame_renderer.sv
// Bench for game_frame_renderer: two instances run side by side, one rendering a full
// composited frame with backpressure and an overrun request, the other covering clipping and mid-frame reset.
module tb_game_frame_renderer;
    logic clk;
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance A signals
    logic        a_resetn, a_start, a_busy, a_done, a_overrun;
    logic [7:0]  a_dino_y, a_scol, a_srow;
    logic [15:0] a_obs_x, a_obs_h;
    logic [5:0]  a_obs_col;
    logic [1:0]  a_obs_en;
    logic [2:0]  a_rom;
    game_frame_renderer_if a_if ();

    // Instance B signals
    logic        b_resetn, b_start, b_busy, b_done, b_overrun;
    logic [7:0]  b_dino_y, b_scol, b_srow;
    logic [15:0] b_obs_x, b_obs_h;
    logic [5:0]  b_obs_col;
    logic [1:0]  b_obs_en;
    logic [2:0]  b_rom;
    game_frame_renderer_if b_if ();

    game_frame_renderer u_dut_a (
        .clk(clk), .resetn(a_resetn), .frame_start(a_start), .dino_y(a_dino_y),
        .obs_x(a_obs_x), .obs_h(a_obs_h), .obs_col(a_obs_col), .obs_en(a_obs_en),
        .sprite_col(a_scol), .sprite_row(a_srow), .sprite_color(a_rom),
        .plot(a_if.master), .busy(a_busy), .frame_done(a_done), .frame_overrun(a_overrun)
    );

    game_frame_renderer u_dut_b (
        .clk(clk), .resetn(b_resetn), .frame_start(b_start), .dino_y(b_dino_y),
        .obs_x(b_obs_x), .obs_h(b_obs_h), .obs_col(b_obs_col), .obs_en(b_obs_en),
        .sprite_col(b_scol), .sprite_row(b_srow), .sprite_color(b_rom),
        .plot(b_if.master), .busy(b_busy), .frame_done(b_done), .frame_overrun(b_overrun)
    );

    // Synchronous sprite ROMs: A is solid 3'b010 with a transparent top-left texel, B fully transparent.
    always @(posedge clk) a_rom <= (a_scol == 8'd0 && a_srow == 8'd0) ? 3'b101 : 3'b010;
    assign b_rom = 3'b101;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scene A: dino at row 84, ch0 x36 h30 col 001, ch1 x40 h20 col 100.
    function automatic logic [2:0] exp_a(input int px, input int py);
        if (py >= 100) return 3'b000;
        if (px >= 10 && px <= 25 && py >= 84 && py <= 99)
            return (px == 10 && py == 84) ? 3'b111 : 3'b010;
        if (px >= 36 && px <= 43 && py >= 70) return 3'b001;
        if (px >= 44 && px <= 47 && py >= 80) return 3'b100;
        return 3'b111;
    endfunction

    // Scene B: ch0 at x155 taller than the ground (full column, clipped at 159), ch1 h=0.
    function automatic logic [2:0] exp_b(input int px, input int py);
        if (py >= 100) return 3'b000;
        if (px >= 155) return 3'b110;
        return 3'b111;
    endfunction

    task automatic run_a();
        int ex = 0, ey = 0, cyc = 0, stall = 0, acc = 0, done_cnt = 0, ov_cnt = 0;
        bit pend_done = 0, finished = 0, ov_sent = 0, ov_pend = 0, stalling = 0;
        a_dino_y  = 8'd84;
        a_obs_x   = {8'd40, 8'd36};
        a_obs_h   = {8'd20, 8'd30};
        a_obs_col = {3'b100, 3'b001};
        a_obs_en  = 2'b11;
        a_if.plot_ready = 1'b1;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("a_busy_t1", a_busy, 1);
        chk("a_vld_t1", a_if.plot_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("a_vld_t3", a_if.plot_valid, 0);
        @(negedge clk);
        chk("a_vld_t4", a_if.plot_valid, 1);
        while (!finished && cyc < 90000) begin
            if (a_done) done_cnt++;
            if (a_overrun) ov_cnt++;
            if (pend_done) begin
                chk("a_done_after_last", a_done, 1);
                chk("a_busy_after_last", a_busy, 0);
                finished = 1;
            end
            if (ov_pend) begin
                chk("a_overrun_pulse", a_overrun, 1);
                a_start = 1'b0;
                ov_pend = 0;
            end
            if (stalling) chk("a_bp_valid", a_if.plot_valid, 1);
            stalling = 0;
            if (!finished && a_if.plot_valid) begin
                if (ex == 5 && ey == 0 && stall < 10) begin
                    a_if.plot_ready = 1'b0;
                    stall++;
                    stalling = 1;
                    chk("a_bp_hold", {a_if.x, a_if.y, a_if.color}, {8'd5, 8'd0, 3'b111});
                end else begin
                    a_if.plot_ready = 1'b1;
                    chk($sformatf("a_pix_%0d_%0d", ex, ey), {a_if.x, a_if.y, a_if.color},
                        {ex[7:0], ey[7:0], exp_a(ex, ey)});
                    acc++;
                    if (ex == 159 && ey == 119) pend_done = 1;
                    if (ex == 159) begin ex = 0; ey++; end else ex++;
                end
            end
            if (!ov_sent && acc == 1000) begin
                a_dino_y = 8'd50;
                a_start  = 1'b1;
                ov_sent  = 1;
                ov_pend  = 1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("a_frame_finished", finished, 1);
        chk("a_accepted", acc, 19200);
        chk("a_done_count", done_cnt, 1);
        chk("a_overrun_count", ov_cnt, 1);
        chk("a_stall_cycles", stall, 10);
    endtask

    task automatic run_b();
        int ex = 0, ey = 0, cyc = 0, n = 0, done_cnt = 0;
        bit hit = 0;
        b_dino_y  = 8'd0;
        b_obs_x   = {8'd60, 8'd155};
        b_obs_h   = {8'd0, 8'd200};
        b_obs_col = {3'b011, 3'b110};
        b_obs_en  = 2'b11;
        b_if.plot_ready = 1'b1;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (!hit && cyc < 50000) begin
            if (b_done) done_cnt++;
            if (b_if.plot_valid) begin
                if (ex == 80 && ey == 60) begin
                    b_resetn = 1'b0;
                    hit = 1;
                end else begin
                    chk($sformatf("b_pix_%0d_%0d", ex, ey), {b_if.x, b_if.y, b_if.color},
                        {ex[7:0], ey[7:0], exp_b(ex, ey)});
                    if (ex == 159) begin ex = 0; ey++; end else ex++;
                end
            end
            if (!hit) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("b_reached_80_60", hit, 1);
        @(negedge clk);
        b_resetn = 1'b1;
        chk("b_rst_x", b_if.x, 0);
        chk("b_rst_y", b_if.y, 0);
        chk("b_rst_color", b_if.color, 3'b111);
        chk("b_rst_valid", b_if.plot_valid, 0);
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_done", b_done, 0);
        chk("b_rst_overrun", b_overrun, 0);
        chk("b_rst_scol", b_scol, 0);
        chk("b_rst_srow", b_srow, 0);
        repeat (30) begin
            @(negedge clk);
            if (b_done) done_cnt++;
        end
        chk("b_no_done_after_reset", done_cnt, 0);
        chk("b_idle_after_reset", b_busy, 0);
        // Restart with obstacles disabled: the x=155 column must now be background.
        b_obs_en = 2'b00;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        ex = 0; ey = 0; cyc = 0;
        while (n < 170 && cyc < 2000) begin
            if (b_if.plot_valid) begin
                chk($sformatf("b2_pix_%0d_%0d", ex, ey), {b_if.x, b_if.y, b_if.color},
                    {ex[7:0], ey[7:0], 3'b111});
                n++;
                if (ex == 159) begin ex = 0; ey++; end else ex++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2_pixels_seen", n, 170);
    endtask

    initial begin
        a_resetn = 1'b0; b_resetn = 1'b0;
        a_start = 1'b0;  b_start = 1'b0;
        a_dino_y = '0; a_obs_x = '0; a_obs_h = '0; a_obs_col = '0; a_obs_en = '0;
        b_dino_y = '0; b_obs_x = '0; b_obs_h = '0; b_obs_col = '0; b_obs_en = '0;
        a_if.plot_ready = 1'b1;
        b_if.plot_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_rst_x", a_if.x, 0);
        chk("a_rst_y", a_if.y, 0);
        chk("a_rst_color", a_if.color, 3'b111);
        chk("a_rst_valid", a_if.plot_valid, 0);
        chk("a_rst_busy", a_busy, 0);
        chk("a_rst_done", a_done, 0);
        chk("a_rst_overrun", a_overrun, 0);
        a_resetn = 1'b1;
        b_resetn = 1'b1;
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
